// File: rtl/shift_reg_arbiter_ctrl_pkg.sv
// Shared definitions for the two-requester serial shift-register controller.
package shift_reg_arbiter_ctrl_pkg;

  // Width of the requester id carried with each result.
  localparam int REQ_ID_W = 1;

  // Sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SHIFT   = 2'd1,
    ST_CAPTURE = 2'd2
  } state_t;

endpackage

// File: rtl/shift_reg_arbiter_ctrl_if.sv
// Bus between the requesters/datapath (master side) and the controller (slave side).
//
// Handshake: a word from requester i is accepted on a rising clock edge where
// req_valid[i] && req_ready[i]. req_ready is at most one-hot and is raised only
// while the controller is idle. A requester may drop req_valid at any time
// before acceptance; nothing is taken unless both are high on the same edge.
// rx_valid is a single-cycle pulse; rx_data/rx_id/rx_err hold until the next
// result.
interface shift_reg_arbiter_ctrl_if #(
  parameter int WIDTH = 4
);
  import shift_reg_arbiter_ctrl_pkg::*;

  logic [1:0]          req_valid;
  logic [WIDTH-1:0]    req_data0;
  logic [WIDTH-1:0]    req_data1;
  logic [1:0]          req_ready;
  logic                sr_en;
  logic                sr_serial_in;
  logic [WIDTH-1:0]    sr_q;
  logic                busy;
  logic                rx_valid;
  logic [WIDTH-1:0]    rx_data;
  logic [REQ_ID_W-1:0] rx_id;
  logic                rx_err;
  state_t              dbg_state;

  modport master (
    output req_valid, req_data0, req_data1, sr_q,
    input  req_ready, sr_en, sr_serial_in, busy,
           rx_valid, rx_data, rx_id, rx_err, dbg_state
  );

  modport slave (
    input  req_valid, req_data0, req_data1, sr_q,
    output req_ready, sr_en, sr_serial_in, busy,
           rx_valid, rx_data, rx_id, rx_err, dbg_state
  );

endinterface

// File: rtl/shift_reg_arbiter_ctrl_rr_arbiter_2.sv
// Combinational two-way round-robin grant: on contention the requester that
// was not served last wins.
module rr_arbiter_2 (
  input  logic [1:0] req_valid_i,
  input  logic       last_grant_i,
  output logic       grant_o,
  output logic       grant_valid_o
);

  // Pick the winner from the current requests and the previous grant.
  always_comb begin
    grant_valid_o = |req_valid_i;
    grant_o       = 1'b0;
    case (req_valid_i)
      2'b11:   grant_o = ~last_grant_i;
      2'b10:   grant_o = 1'b1;
      default: grant_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/shift_register_4bit.sv
// Serial-in, parallel-out shift register used as the shared datapath.
module shift_register_4bit #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             serial_in,
  output logic [WIDTH-1:0] q
);

  // Shift towards the MSB, new bit enters at bit 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (en) begin
      q <= {q[WIDTH-2:0], serial_in};
    end
  end

endmodule

// File: rtl/shift_reg_arbiter_ctrl.sv
// Arbitrates two word requesters, serializes the granted word MSB-first into
// an external shift register, then samples the register and reports the word
// with the owner id and a loopback-mismatch flag.
module shift_reg_arbiter_ctrl
  import shift_reg_arbiter_ctrl_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  shift_reg_arbiter_ctrl_if.slave   bus
);

  localparam int CNT_W = $clog2(WIDTH);

  state_t              state_q;
  logic [WIDTH-1:0]    tx_buf_q;
  logic [WIDTH-1:0]    exp_buf_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                last_grant_q;
  logic                cur_id_q;
  logic                rx_valid_q;
  logic [WIDTH-1:0]    rx_data_q;
  logic [REQ_ID_W-1:0] rx_id_q;
  logic                rx_err_q;

  logic                grant;
  logic                grant_valid;
  logic                accept_ok;
  logic [WIDTH-1:0]    grant_data;

  rr_arbiter_2 u_arb (
    .req_valid_i   (bus.req_valid),
    .last_grant_i  (last_grant_q),
    .grant_o       (grant),
    .grant_valid_o (grant_valid)
  );

  // Ready only while idle and out of reset, so a word can never be half-taken.
  assign accept_ok  = (state_q == ST_IDLE) && grant_valid && !rst;
  assign grant_data = grant ? bus.req_data1 : bus.req_data0;

  assign bus.req_ready    = accept_ok ? (2'b01 << grant) : 2'b00;
  assign bus.sr_en        = (state_q == ST_SHIFT);
  assign bus.sr_serial_in = (state_q == ST_SHIFT) & tx_buf_q[WIDTH-1];
  assign bus.busy         = (state_q != ST_IDLE);
  assign bus.rx_valid     = rx_valid_q;
  assign bus.rx_data      = rx_data_q;
  assign bus.rx_id        = rx_id_q;
  assign bus.rx_err       = rx_err_q;
  assign bus.dbg_state    = state_q;

  // Sequencer: accept a word, shift it out over WIDTH cycles, capture the result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      tx_buf_q     <= '0;
      exp_buf_q    <= '0;
      cnt_q        <= '0;
      last_grant_q <= 1'b1;
      cur_id_q     <= 1'b0;
      rx_valid_q   <= 1'b0;
      rx_data_q    <= '0;
      rx_id_q      <= '0;
      rx_err_q     <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (grant_valid) begin
            tx_buf_q     <= grant_data;
            exp_buf_q    <= grant_data;
            cur_id_q     <= grant;
            last_grant_q <= grant;
            cnt_q        <= CNT_W'(WIDTH - 1);
            state_q      <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          tx_buf_q <= {tx_buf_q[WIDTH-2:0], 1'b0};
          if (cnt_q == '0) begin
            state_q <= ST_CAPTURE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_CAPTURE: begin
          rx_data_q  <= bus.sr_q;
          rx_id_q    <= cur_id_q;
          rx_err_q   <= (bus.sr_q != exp_buf_q);
          rx_valid_q <= 1'b1;
          state_q    <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_reg_arbiter_ctrl.sv
// Directed bench for shift_reg_arbiter_ctrl with a real shift-register datapath.
module tb_shift_reg_arbiter_ctrl;
  import shift_reg_arbiter_ctrl_pkg::*;

  localparam int WIDTH = 4;
  localparam int EW    = WIDTH + 2;  // {err, id, data}

  logic             clk;
  logic             rst;
  logic             force_zero;
  logic [WIDTH-1:0] dp_q;

  int checks   = 0;
  int failures = 0;
  int rx_count = 0;
  int pushes   = 0;
  logic          prev_rx;
  logic [EW-1:0] exp_q[$];

  shift_reg_arbiter_ctrl_if #(.WIDTH(WIDTH)) bus ();

  shift_reg_arbiter_ctrl #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  shift_register_4bit #(.WIDTH(WIDTH)) u_dp (
    .clk       (clk),
    .rst       (rst),
    .en        (bus.sr_en),
    .serial_in (bus.sr_serial_in),
    .q         (dp_q)
  );

  assign bus.sr_q = force_zero ? '0 : dp_q;

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard time limit
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive-time helper: inputs already set; check ready, queue the expected result, cross the accept edge.
  task automatic accept_one(input string tag, input logic [1:0] exp_ready, input logic [EW-1:0] entry);
    #1;
    check(tag, bus.req_ready, exp_ready);
    exp_q.push_back(entry);
    pushes++;
    @(negedge clk);
  endtask

  // Count negedges from the cycle after an accept until ready reappears.
  task automatic wait_ready(input string tag, input int exp_gap);
    int n;
    n = 0;
    #1;
    while (bus.req_ready == 2'b00 && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    check(tag, n, exp_gap);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("drain", exp_q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Scoreboard: compare every result pulse against the oldest expectation.
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (rst) begin
      prev_rx = 1'b0;
    end else begin
      if (bus.rx_valid) begin
        rx_count++;
        check("rx_single_pulse", prev_rx, 1'b0);
        check("rx_expected_pending", (exp_q.size() != 0), 1'b1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("rx_data", bus.rx_data, e[WIDTH-1:0]);
          check("rx_id", bus.rx_id, e[WIDTH]);
          check("rx_err", bus.rx_err, e[WIDTH+1]);
        end
      end
      prev_rx = bus.rx_valid;
    end
  end

  initial begin
    logic [WIDTH-1:0] w;
    logic             lg;
    logic             g;
    int               rc;

    rst           = 1'b1;
    force_zero    = 1'b0;
    prev_rx       = 1'b0;
    bus.req_valid = 2'b00;
    bus.req_data0 = '0;
    bus.req_data1 = '0;

    // Reset state, with requests present
    repeat (2) @(negedge clk);
    bus.req_valid = 2'b11;
    #1;
    check("rst_req_ready", bus.req_ready, 2'b00);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_sr_en", bus.sr_en, 1'b0);
    check("rst_sr_serial_in", bus.sr_serial_in, 1'b0);
    check("rst_rx_valid", bus.rx_valid, 1'b0);
    check("rst_rx_data", bus.rx_data, '0);
    check("rst_rx_id", bus.rx_id, 1'b0);
    check("rst_rx_err", bus.rx_err, 1'b0);
    check("rst_state", bus.dbg_state, ST_IDLE);
    bus.req_valid = 2'b00;
    @(negedge clk);
    rst = 1'b0;

    // Test 1: single word from requester 0
    w = 4'b1011;
    bus.req_data0 = w;
    bus.req_valid = 2'b01;
    accept_one("t1_ready", 2'b01, {1'b0, 1'b0, w});
    bus.req_valid = 2'b00;
    for (int i = 0; i < WIDTH; i++) begin
      #1;
      check("t1_sr_en", bus.sr_en, 1'b1);
      check("t1_serial", bus.sr_serial_in, w[WIDTH-1-i]);
      check("t1_busy", bus.busy, 1'b1);
      check("t1_ready_low", bus.req_ready, 2'b00);
      @(negedge clk);
    end
    #1;
    check("t1_capture_sr_en", bus.sr_en, 1'b0);
    check("t1_capture_busy", bus.busy, 1'b1);
    @(negedge clk);
    check("t1_latency", bus.rx_valid, 1'b1);
    @(negedge clk);
    check("t1_rx_fall", bus.rx_valid, 1'b0);
    check("t1_rx_hold", bus.rx_data, w);

    // Test 2: both requesters held, grants alternate starting at 0
    do_reset();
    bus.req_data0 = 4'h5;
    bus.req_data1 = 4'hA;
    bus.req_valid = 2'b11;
    lg = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) wait_ready("t2_gap", WIDTH + 1);
      g = ~lg;
      accept_one("t2_grant", 2'(2'b01 << g), {1'b0, g, (g ? 4'hA : 4'h5)});
      lg = g;
    end
    bus.req_valid = 2'b00;
    drain();

    // Test 3: back-to-back from requester 1; data changed after acceptance
    bus.req_data1 = 4'h3;
    bus.req_valid = 2'b10;
    accept_one("t3_ready1", 2'b10, {1'b0, 1'b1, 4'h3});
    bus.req_data1 = 4'hC;
    wait_ready("t3_gap", WIDTH + 1);
    check("t3_ready_with_rx", bus.rx_valid, 1'b1);
    accept_one("t3_ready2", 2'b10, {1'b0, 1'b1, 4'hC});
    bus.req_valid = 2'b00;
    drain();

    // Test 4: broken datapath reads back zero
    force_zero    = 1'b1;
    bus.req_data0 = 4'h9;
    bus.req_valid = 2'b01;
    accept_one("t4_ready", 2'b01, {1'b1, 1'b0, 4'h0});
    bus.req_valid = 2'b00;
    drain();
    force_zero = 1'b0;

    // Test 5: reset in the middle of shifting
    rc = rx_count;
    bus.req_data0 = 4'h6;
    bus.req_valid = 2'b01;
    #1;
    check("t5_ready", bus.req_ready, 2'b01);
    @(negedge clk);
    bus.req_valid = 2'b11;
    bus.req_data1 = 4'hE;
    repeat (2) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("t5_busy_async", bus.busy, 1'b0);
    check("t5_sr_en_async", bus.sr_en, 1'b0);
    check("t5_ready_async", bus.req_ready, 2'b00);
    check("t5_state_async", bus.dbg_state, ST_IDLE);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("t5_no_rx_aborted", rx_count, rc);
    accept_one("t5_first_grant", 2'b01, {1'b0, 1'b0, 4'h6});
    bus.req_valid = 2'b00;
    drain();
    check("t5_rx_count", rx_count, rc + 1);

    // Test 6: short request while busy is never taken
    bus.req_data0 = 4'hA;
    bus.req_valid = 2'b01;
    accept_one("t6_ready", 2'b01, {1'b0, 1'b0, 4'hA});
    bus.req_data1 = 4'hF;
    bus.req_valid = 2'b10;
    #1;
    check("t6_busy_ready", bus.req_ready, 2'b00);
    @(negedge clk);
    bus.req_valid = 2'b00;
    drain();
    repeat (10) @(negedge clk);
    check("final_rx_count", rx_count, pushes);
    check("final_queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
